// File: rtl/controller_pkg.sv
// Shared definitions for the processor control unit: state encodings,
// opcode values, ALU function selects and the opcode-to-state decode.
package controller_pkg;

  localparam int unsigned INSTR_W = 16;

  // State encodings are visible on OutState for the debug display.
  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_NOOP   = 4'd3,
    ST_LOAD_A = 4'd4,
    ST_LOAD_B = 4'd5,
    ST_STORE  = 4'd6,
    ST_ADD    = 4'd7,
    ST_SUB    = 4'd8,
    ST_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  // First execute state for an opcode; unused opcodes fall through to NOOP.
  function automatic state_t decode_op(input logic [3:0] op);
    state_t st;
    case (op)
      OP_STORE: st = ST_STORE;
      OP_LOAD:  st = ST_LOAD_A;
      OP_ADD:   st = ST_ADD;
      OP_SUB:   st = ST_SUB;
      OP_HALT:  st = ST_HALT;
      default:  st = ST_NOOP;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/instr_reg.sv
// Instruction register: captures the instruction word when load is high,
// holds it otherwise, clears to zero on reset.
module instr_reg
  import controller_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               load,
  input  logic [INSTR_W-1:0] d,
  output logic [INSTR_W-1:0] q
);

  // Load-enabled capture with asynchronous clear.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/controller_fsm.sv
// Moore control unit for the 16-bit processor. Fetches through the program
// counter, latches the instruction, and steps the data memory, register file
// and ALU through the execute states. Every output is a function of the
// current state and the latched instruction only.
module controller_fsm
  import controller_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] IM_Q,
  output logic        PC_Clr,
  output logic        PC_Up,
  output logic [7:0]  D_Addr,
  output logic        D_Wr,
  output logic        RF_s,
  output logic [3:0]  RF_W_Addr,
  output logic        RF_W_En,
  output logic [3:0]  RF_Ra_Addr,
  output logic [3:0]  RF_Rb_Addr,
  output logic [2:0]  ALU_s0,
  output logic [3:0]  OutState
);

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] ir;
  logic [3:0]  opcode;

  // IR only captures during FETCH, on the same edge the PC advances.
  instr_reg u_instr_reg (
    .Clk   (Clk),
    .Reset (Reset),
    .load  (state_reg == ST_FETCH),
    .d     (IM_Q),
    .q     (ir)
  );

  assign opcode   = ir[15:12];
  assign OutState = state_reg;

  // State register; reset returns to INIT immediately, which also drops
  // any write strobe of an aborted instruction in the same cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= ST_INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and output decode. Address fields follow IR in every state;
  // only the strobes and the function selects depend on the state.
  always_comb begin
    state_next = state_reg;
    PC_Clr     = 1'b0;
    PC_Up      = 1'b0;
    D_Wr       = 1'b0;
    RF_W_En    = 1'b0;
    RF_s       = 1'b0;
    ALU_s0     = ALU_PASS;
    D_Addr     = ir[11:4];
    RF_W_Addr  = ir[3:0];
    RF_Rb_Addr = ir[7:4];
    // STORE reads its source register from the low nibble; arithmetic
    // reads operand A from bits 11:8.
    RF_Ra_Addr = (opcode == OP_STORE) ? ir[3:0] : ir[11:8];

    case (state_reg)
      ST_INIT: begin
        PC_Clr     = 1'b1;
        PC_Up      = 1'b1;
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        PC_Up      = 1'b1;
        state_next = ST_DECODE;
      end
      ST_DECODE: begin
        state_next = decode_op(opcode);
      end
      ST_NOOP: begin
        state_next = ST_FETCH;
      end
      ST_LOAD_A: begin
        // Address presented one cycle early so the synchronous RAM read
        // is ready when LOAD_B writes it back.
        RF_s       = 1'b1;
        state_next = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        RF_s       = 1'b1;
        RF_W_En    = 1'b1;
        state_next = ST_FETCH;
      end
      ST_STORE: begin
        D_Wr       = 1'b1;
        state_next = ST_FETCH;
      end
      ST_ADD: begin
        ALU_s0     = ALU_ADD;
        RF_W_En    = 1'b1;
        state_next = ST_FETCH;
      end
      ST_SUB: begin
        ALU_s0     = ALU_SUB;
        RF_W_En    = 1'b1;
        state_next = ST_FETCH;
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

endmodule

// File: doc/controller_fsm.md
# controller_fsm

Moore-style control unit for the 16-bit processor; drives the program counter's `Clr`/`Up` pins and consumes the instruction words they address. It latches each instruction from instruction memory, decodes it, and sequences the data memory, register file and ALU through multi-cycle execute states. It sits between the program counter/instruction ROM and the datapath.

## Interface
- No parameters. Widths are fixed: 16-bit instruction, 7-bit PC, 8-bit data address, 4-bit register address.
- `Clk` in 1: rising-edge clock.
- `Reset` in 1: asynchronous, active-high reset.
- `IM_Q` in 16: instruction memory word at the current PC address. Valid combinationally while PC is stable.
- `PC_Clr` out 1: to PC `Clr`.
- `PC_Up` out 1: to PC `Up`.
- `D_Addr` out 8: data memory address.
- `D_Wr` out 1: data memory write enable.
- `RF_s` out 1: register-file write-data mux. 1 = data memory, 0 = ALU.
- `RF_W_Addr` out 4: register-file write address.
- `RF_W_En` out 1: register-file write enable.
- `RF_Ra_Addr` out 4: register-file read port A address.
- `RF_Rb_Addr` out 4: register-file read port B address.
- `ALU_s0` out 3: ALU function. 000 = pass A, 001 = add, 010 = subtract.
- `OutState` out 4: current state encoding, for debug display.

## Operation
- Instruction fields, using IR = latched instruction:
  - Opcode = IR[15:12].
  - LOAD/STORE: D_Addr = IR[11:4], register = IR[3:0].
  - ADD/SUB: Ra = IR[11:8], Rb = IR[7:4], Rc (destination) = IR[3:0].
- Opcodes:
  - 0000 NOOP.
  - 0001 STORE: D[IR[11:4]] ← RF[IR[3:0]].
  - 0010 LOAD: RF[IR[3:0]] ← D[IR[11:4]].
  - 0011 ADD: RF[Rc] ← RF[Ra] + RF[Rb].
  - 0100 SUB: RF[Rc] ← RF[Ra] − RF[Rb].
  - 0101 HALT.
  - 0110–1111: treated as NOOP.
- State encodings (`OutState`): INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9.
- State actions. All outputs not listed are 0.
  - INIT: `PC_Clr`=1, `PC_Up`=1. Next state: FETCH.
  - FETCH: IR ← `IM_Q`; `PC_Up`=1. Next state: DECODE.
  - DECODE: no strobes. Next state by opcode: NOOP, LOAD_A, STORE, ADD, SUB or HALT.
  - NOOP: next state FETCH.
  - LOAD_A: `D_Addr`=IR[11:4], `RF_s`=1, `RF_W_Addr`=IR[3:0], write not enabled (waits for synchronous RAM read). Next state: LOAD_B.
  - LOAD_B: same addresses and `RF_s`=1, plus `RF_W_En`=1. Next state: FETCH.
  - STORE: `D_Addr`=IR[11:4], `RF_Ra_Addr`=IR[3:0], `D_Wr`=1. Next state: FETCH.
  - ADD: `RF_Ra_Addr`=Ra, `RF_Rb_Addr`=Rb, `RF_W_Addr`=Rc, `ALU_s0`=001, `RF_s`=0, `RF_W_En`=1. Next state: FETCH.
  - SUB: same as ADD, with `ALU_s0`=010.
  - HALT: no strobes. Stays in HALT until `Reset`.
- IR is loaded only in FETCH and holds its value in every other state.
- Address fields are driven from IR in every state. Only the strobes (`D_Wr`, `RF_W_En`, `PC_Up`, `PC_Clr`) are state-gated.

## Timing
- Reset (asynchronous): state ← INIT, IR ← 16'h0000.
- Outputs while `Reset` is held: `PC_Clr`=1, `PC_Up`=1, `OutState`=0, all other outputs 0.
- Reset asserted mid-instruction aborts it immediately. Any pending `D_Wr` or `RF_W_En` drops in the same cycle, without waiting for a clock edge.
- All outputs are combinational from state and IR only; no path from `IM_Q` reaches any output.
- Cycles per instruction, counted from FETCH entry back to FETCH:
  - NOOP, STORE, ADD, SUB: 3 cycles.
  - LOAD: 4 cycles.
  - HALT: terminal.
- PC advances exactly once per instruction, on the FETCH edge. IR captures the word for the pre-increment address on that same edge.
- PC saturation at 127 is owned by the PC. The controller keeps fetching and re-executes the instruction at address 127.

## Structure
- Shared package `controller_pkg`:
  - `state_t` enum (4-bit, encodings above).
  - Opcode localparams `OP_NOOP` … `OP_HALT`.
  - ALU select constants `ALU_PASS`, `ALU_ADD`, `ALU_SUB`.
- Sub-module `instr_reg`: 16-bit register with async reset and load enable. Holds IR.
- Everything else in `controller_fsm`: one `always_ff` for state, one `always_comb` for next-state and output logic.

## Test plan
- Reset pulse mid-LOAD_A → `OutState`=0 and `PC_Clr`=`PC_Up`=1 immediately. After release: FETCH, with `OutState`=1 on the first edge.
- `IM_Q`=16'h2A53 (LOAD) → sequence FETCH, DECODE, LOAD_A, LOAD_B.
  - LOAD_A: `D_Addr`=8'hA5, `RF_s`=1, `RF_W_Addr`=3, `RF_W_En`=0.
  - LOAD_B: `RF_W_En`=1.
  - Back to FETCH after 4 cycles; `PC_Up` high exactly once.
- `IM_Q`=16'h1F02 (STORE) → STORE state with `D_Addr`=8'hF0, `RF_Ra_Addr`=2, `D_Wr`=1 for exactly one cycle.
- `IM_Q`=16'h3125 (ADD) → `RF_Ra_Addr`=1, `RF_Rb_Addr`=2, `RF_W_Addr`=5, `ALU_s0`=001, `RF_W_En`=1 for one cycle.
- `IM_Q`=16'h4125 (SUB) → same signals as ADD except `ALU_s0`=010.
- `IM_Q`=16'h5000 (HALT) → `OutState`=9 held for 20 cycles with all strobes 0.
- `IM_Q`=16'hE123 (undefined opcode) → NOOP path, back to FETCH in 3 cycles with no writes.
